// File: rtl/alu_pkg.sv
// alu_pkg: op encoding, control states and status-word flag positions shared by the ALU slice
package alu_pkg;
  localparam int OP_W = 3;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
  localparam int FLAG_ZERO        = 0;
  localparam int FLAG_CARRY       = 1;
  localparam int FLAG_OVERFLOW    = 2;
  localparam int FLAG_DIV_BY_ZERO = 3;
  localparam int FLAG_W           = 4;
  function automatic logic is_multicycle(input logic [2:0] op, input logic b_nz);
    return op == OP_MUL || (op == OP_DIV && b_nz);
  endfunction
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative shift-add multiplier / restoring divider, one step per clock
module seq_muldiv #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             fin
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] acc_lo, acc_hi, m, diff;
  logic [WIDTH:0]   msum, shifted;
  logic [CW-1:0]    cnt;
  logic             run, div, ge;
  // lo/hi are the results of the step taken at the coming edge, so the last step is visible during fin
  always_comb begin
    msum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = shifted >= {1'b0, m};
    diff    = shifted[WIDTH-1:0] - m;
    lo      = div ? {acc_lo[WIDTH-2:0], ge} : {msum[0], acc_lo[WIDTH-1:1]};
    hi      = div ? (ge ? diff : shifted[WIDTH-1:0]) : msum[WIDTH:1];
  end
  assign fin = run && cnt == CW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      acc_lo <= '0;
      acc_hi <= '0;
      m      <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      div    <= 1'b0;
    end else if (load) begin
      acc_lo <= a;
      acc_hi <= '0;
      m      <= b;
      cnt    <= CW'(WIDTH);
      run    <= 1'b1;
      div    <= op_is_div;
    end else if (run) begin
      acc_lo <= lo;
      acc_hi <= hi;
      cnt    <= cnt - CW'(1);
      run    <= !fin;
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/done handshake, iterative MUL/DIV and status flags
module seq_alu import alu_pkg::*; #(
  parameter int WIDTH = 19,
  parameter int OPW   = OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);
  state_t state, state_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res1, eng_lo, eng_hi;
  logic [FLAG_W-1:0] flags, fl_one, fl_eng;
  logic car1, is_div, load, eng_fin;
  assign is_div = alu_op == OP_DIV;
  assign load   = state == IDLE && start && is_multicycle(alu_op, b != '0);
  assign busy   = state != IDLE;
  assign zero        = flags[FLAG_ZERO];
  assign carry       = flags[FLAG_CARRY];
  assign overflow    = flags[FLAG_OVERFLOW];
  assign div_by_zero = flags[FLAG_DIV_BY_ZERO];
  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk), .rst(rst), .load(load), .op_is_div(is_div),
    .a(a), .b(b), .lo(eng_lo), .hi(eng_hi), .fin(eng_fin)
  );
  // single-cycle path; DIV here only ever means divide-by-zero, which yields a zero quotient
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    res1 = '0;
    car1 = 1'b0;
    case (alu_op)
      OP_ADD: {car1, res1} = sum;
      OP_SUB: begin
        res1 = a - b;
        car1 = a < b;
      end
      OP_AND: res1 = a & b;
      OP_OR:  res1 = a | b;
      OP_XOR: res1 = a ^ b;
      OP_NOT: res1 = ~a;
      default: res1 = '0;
    endcase
    fl_one = '0;
    fl_one[FLAG_ZERO]        = res1 == '0;
    fl_one[FLAG_CARRY]       = car1;
    fl_one[FLAG_DIV_BY_ZERO] = is_div;
    fl_eng = '0;
    fl_eng[FLAG_ZERO]        = eng_lo == '0;
    fl_eng[FLAG_OVERFLOW]    = state == MUL_RUN && eng_hi != '0;
  end
  always_comb
    state_nxt = state == IDLE ? (load ? (is_div ? DIV_RUN : MUL_RUN) : IDLE)
                              : (eng_fin ? IDLE : state);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk)
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && eng_fin) begin
        result    <= eng_lo;
        result_hi <= eng_hi;
        flags     <= fl_eng;
        done      <= 1'b1;
      end else if (state == IDLE && start && !load) begin
        result    <= res1;
        result_hi <= '0;
        flags     <= fl_one;
        done      <= 1'b1;
      end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu, expected results queued at issue and checked on done
module tb_seq_alu;
  import alu_pkg::*;
  localparam int W = 19;
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    int           due;
    logic [2:0]   op;
  } exp_t;
  logic clk, rst, start, busy, done, zero, carry, overflow, div_by_zero;
  logic [2:0] alu_op;
  logic [W-1:0] a, b, result, result_hi;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int vec = 0;
  int err = 0;
  seq_alu #(.WIDTH(W), .OPW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .carry(carry), .overflow(overflow), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    longint unsigned ax, by, p;
    ax = x; by = y; p = 0;
    r.res = '0; r.hi = '0; r.fl = '0; r.op = op; r.due = 0;
    case (op)
      OP_ADD: begin p = ax + by; r.res = p[W-1:0]; r.fl[1] = p[W]; end
      OP_SUB: begin r.res = W'(ax - by); r.fl[1] = ax < by; end
      OP_MUL: begin p = ax * by; r.res = p[W-1:0]; r.hi = p[2*W-1:W]; r.fl[2] = r.hi != 0; end
      OP_DIV: if (by == 0) r.fl[3] = 1'b1; else begin r.res = W'(ax / by); r.hi = W'(ax % by); end
      OP_AND: r.res = x & y;
      OP_OR:  r.res = x | y;
      OP_XOR: r.res = x ^ y;
      default: r.res = ~x;
    endcase
    r.fl[0] = r.res == 0;
    return r;
  endfunction
  always @(negedge clk)
    if (rst === 1'b0 && done === 1'b1) begin
      if (q.size() == 0) begin
        vec++; err++;
        $display("FAIL unexpected_done at cycle %0d result=%0d", cyc, result);
      end else begin
        e = q.pop_front();
        vec++;
        if (result !== e.res) begin err++; $display("FAIL op%0d result got %0d want %0d", e.op, result, e.res); end
        vec++;
        if (result_hi !== e.hi) begin err++; $display("FAIL op%0d result_hi got %0d want %0d", e.op, result_hi, e.hi); end
        vec++;
        if ({div_by_zero, overflow, carry, zero} !== e.fl) begin
          err++; $display("FAIL op%0d flags{dbz,ovf,c,z} got %b want %b", e.op, {div_by_zero, overflow, carry, zero}, e.fl);
        end
        vec++;
        if (cyc !== e.due || busy !== 1'b0) begin
          err++; $display("FAIL op%0d done_timing got cycle %0d busy %b want cycle %0d busy 0", e.op, cyc, busy, e.due);
        end
      end
    end
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit track);
    exp_t r;
    start = 1'b1; alu_op = op; a = x; b = y;
    r = model(op, x, y);
    r.due = cyc + (is_multicycle(op, y != 0) ? W + 1 : 1);
    if (track) q.push_back(r);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({busy, done, result, result_hi, zero, carry, overflow, div_by_zero} !== '0) begin
      err++; $display("FAIL reset_state got busy=%b done=%b result=%0d hi=%0d", busy, done, result, result_hi);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single();
    issue(OP_ADD, 19'd524287, 19'd1, 1);
    vec++;
    if (busy !== 1'b0) begin err++; $display("FAIL add_busy got %b want 0", busy); end
    wait_idle();
    issue(OP_SUB, 19'd5, 19'd7, 1);
    wait_idle();
  endtask
  task automatic test_mul();
    issue(OP_MUL, 19'd1000, 19'd1000, 1);
    for (int i = 0; i < W; i++) begin
      vec++;
      if (busy !== 1'b1) begin err++; $display("FAIL mul_busy step %0d got %b want 1", i, busy); end
      @(negedge clk);
    end
    vec++;
    if (busy !== 1'b0) begin err++; $display("FAIL mul_busy_drop got %b want 0", busy); end
    wait_idle();
    issue(OP_MUL, 19'd3, 19'd4, 1);
    wait_idle();
  endtask
  task automatic test_div();
    issue(OP_DIV, 19'd100, 19'd7, 1);
    wait_idle();
    issue(OP_DIV, 19'd9, 19'd0, 1);
    wait_idle();
    issue(OP_ADD, 19'd1, 19'd1, 1);
    wait_idle();
  endtask
  task automatic test_busy_ignore();
    issue(OP_MUL, 19'd777, 19'd12345, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; alu_op = OP_ADD; a = 19'd1; b = 19'd1;
    @(negedge clk);
    start = 1'b0;
    vec++;
    if (busy !== 1'b1) begin err++; $display("FAIL ignore_busy got %b want 1", busy); end
    wait_idle();
  endtask
  task automatic test_done_overlap();
    bit seen;
    seen = 0;
    issue(OP_MUL, 19'd3, 19'd4, 1);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    vec++;
    if (!seen) begin err++; $display("FAIL overlap_done_wait got no done want done within 40 cycles"); end
    issue(OP_XOR, 19'd5, 19'd5, 1);
    wait_idle();
  endtask
  task automatic test_abort();
    issue(OP_DIV, 19'd100, 19'd7, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({busy, done, result, result_hi, zero, carry, overflow, div_by_zero} !== '0) begin
      err++; $display("FAIL abort_state got busy=%b done=%b result=%0d hi=%0d", busy, done, result, result_hi);
    end
    repeat (25) @(negedge clk);
    issue(OP_ADD, 19'd2, 19'd3, 1);
    wait_idle();
  endtask
  task automatic test_back_to_back();
    issue(OP_AND, 19'h7_0F0F, 19'h3_FF00, 1);
    issue(OP_OR,  19'h1_0001, 19'h0_F000, 1);
    issue(OP_NOT, 19'h0_00FF, 19'h1_2345, 1);
    issue(OP_SUB, 19'd7, 19'd7, 1);
    issue(OP_ADD, 19'd300000, 19'd300000, 1);
    wait_idle();
  endtask
  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 20));
      issue(op, x, y, 1);
      wait_idle();
    end
  endtask
  initial begin
    clk = 0; rst = 1; start = 0; alu_op = '0; a = '0; b = '0;
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_busy_ignore();
    test_done_overlap();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    vec++;
    if (q.size() != 0) begin err++; $display("FAIL pending_results got %0d outstanding want 0", q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
